sl_tx_arbiter: RTL and testbench

Shares one SL transmit line pair between `N_REQ` requesters. Each word is granted round-robin and serialized onto `sl0`/`sl1` using the SL two-wire pulse encoding expected by the SL receiver chain:

- idle: both lines high
- '0' bit: low pulse on `sl0`
- '1' bit: low pulse on `sl1`
- word end: both lines low together

The block sits between the bus-side requesters (configuration and loopback test masters) and the SL line drivers. It is the transmit-side counterpart of the SL receiver.

---
 rtl/sl_tx_arbiter_if.sv | 17 +
 rtl/sl_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sl_tx_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sl_tx_arbiter_if.sv
// Requester-side bus of the SL transmit arbiter: per-requester request, word,
// length and the single-cycle acknowledge/reject returned by the arbiter.
interface sl_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    // Handshake: req[i] is a level "valid" held with stable req_data/req_len
    // slices until ack[i] pulses for one cycle (accepted, or rejected when err
    // pulses with it); a requester still holding req after ack asks for another word.
    logic [N_REQ-1:0]    req;
    logic [N_REQ*32-1:0] req_data;
    logic [N_REQ*6-1:0]  req_len;
    logic [N_REQ-1:0]    ack;
    logic                err;

    modport master (output req, req_data, req_len, input ack, err);
    modport slave  (input req, req_data, req_len, output ack, err);
endinterface

// File: rtl/sl_tx_arbiter.sv
// Round-robin arbiter that serializes one granted word at a time onto the SL
// two-wire pulse line pair. Optional odd parity bit: define SL_TX_PARITY_EN.
module sl_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int BIT_LOW  = 4,
    parameter int BIT_HIGH = 4,
    parameter int STOP_LOW = 4,
    parameter int GAP      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    sl_tx_arbiter_if.slave      bus,
    output logic                busy,
    output logic                done,
    output logic [2:0]          cur_id,
    output logic                sl0,
    output logic                sl1,
    output logic [2:0]          state_dbg
);
    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MAX_A = (BIT_LOW > BIT_HIGH) ? BIT_LOW : BIT_HIGH;
    localparam int MAX_B = (STOP_LOW > GAP) ? STOP_LOW : GAP;
    localparam int MAXD  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXD) + 1;
`ifdef SL_TX_PARITY_EN
    localparam logic [5:0] P = 6'd1;
`else
    localparam logic [5:0] P = 6'd0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_BIT_LO, S_BIT_HI, S_STOP, S_GAP} state_t;

    state_t            state_q, state_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic [5:0]        bit_cnt_q, bit_cnt_n;
    logic [31:0]       data_q, data_n;
    logic [5:0]        len_q, len_n;
    logic [PW-1:0]     ptr_q, ptr_n;
    logic [N_REQ-1:0]  ack_q, ack_n;
    logic              err_q, err_n;
    logic [2:0]        id_n;
    logic              busy_n, done_n, sl0_n, sl1_n, bit_n;
    logic              found;
    logic [PW-1:0]     sel, cand;
    logic [5:0]        sel_len;

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign state_dbg = state_q;

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        bit_cnt_n = bit_cnt_q;
        data_n    = data_q;
        len_n     = len_q;
        ptr_n     = ptr_q;
        id_n      = cur_id;
        ack_n     = '0;
        err_n     = 1'b0;
        found     = 1'b0;
        sel       = '0;
        cand      = '0;
        // First requester at or after the pointer, wrapping around.
        for (int k = 0; k < N_REQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % N_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        sel_len = bus.req_len[int'(sel)*6 +: 6];

        case (state_q)
            S_IDLE: begin
                // The cycle that carries an ack is never an arbitration cycle,
                // so a requester dropping req on ack is not served twice.
                if (found && (ack_q == '0)) begin
                    ack_n[sel] = 1'b1;
                    ptr_n      = (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
                    if (sel_len == 6'd0 || sel_len > 6'd32) begin
                        err_n = 1'b1;
                    end else begin
                        data_n    = bus.req_data[int'(sel)*32 +: 32];
                        len_n     = sel_len;
                        bit_cnt_n = '0;
                        cnt_n     = '0;
                        id_n      = 3'(sel);
                        state_n   = S_BIT_LO;
                    end
                end
            end
            S_BIT_LO: begin
                if (cnt_q == CW'(BIT_LOW - 1)) begin
                    cnt_n     = '0;
                    bit_cnt_n = bit_cnt_q + 6'd1;
                    state_n   = S_BIT_HI;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_BIT_HI: begin
                if (cnt_q == CW'(BIT_HIGH - 1)) begin
                    cnt_n   = '0;
                    state_n = (bit_cnt_q == len_q + P) ? S_STOP : S_BIT_LO;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CW'(STOP_LOW - 1)) begin
                    cnt_n   = '0;
                    state_n = S_GAP;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Line levels are derived from the next state so they register with it.
`ifdef SL_TX_PARITY_EN
    logic [31:0] len_mask;
    logic        par_bit;
`endif
    always_comb begin
`ifdef SL_TX_PARITY_EN
        len_mask = (len_q >= 6'd32) ? '1 : ((32'd1 << len_q) - 32'd1);
        par_bit  = ~^(data_q & len_mask);
        bit_n    = (bit_cnt_n < len_n) ? data_n[bit_cnt_n[4:0]] : par_bit;
`else
        bit_n    = data_n[bit_cnt_n[4:0]];
`endif
        sl0_n  = !(((state_n == S_BIT_LO) && !bit_n) || (state_n == S_STOP));
        sl1_n  = !(((state_n == S_BIT_LO) && bit_n) || (state_n == S_STOP));
        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_GAP) && (cnt_n == CW'(GAP - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            len_q     <= '0;
            ptr_q     <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            cur_id    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sl0       <= 1'b1;
            sl1       <= 1'b1;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_cnt_q <= bit_cnt_n;
            data_q    <= data_n;
            len_q     <= len_n;
            ptr_q     <= ptr_n;
            ack_q     <= ack_n;
            err_q     <= err_n;
            cur_id    <= id_n;
            busy      <= busy_n;
            done      <= done_n;
            sl0       <= sl0_n;
            sl1       <= sl1_n;
        end
    end
endmodule

// File: tb/tb_sl_tx_arbiter.sv
// Directed bench for sl_tx_arbiter: line decoder feeding a word scoreboard,
// plus arbitration order, latency, reject and reset-abort checks.
module tb_sl_tx_arbiter;
    localparam int N_REQ = 4;
    localparam int BL = 2, BH = 2, SL = 2, GP = 4;
`ifdef SL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy, done, sl0, sl1;
    logic [2:0] cur_id, state_dbg;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    sl_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    sl_tx_arbiter #(
        .N_REQ(N_REQ), .BIT_LOW(BL), .BIT_HIGH(BH), .STOP_LOW(SL), .GAP(GP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done(done),
        .cur_id(cur_id), .sl0(sl0), .sl1(sl1), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int lat(input int len);
        return (len + P) * (BL + BH) + SL + GP;
    endfunction

    // {bit count, bits LSB first} as they should appear on the lines
    function automatic logic [38:0] word_model(input logic [31:0] d, input int len);
        logic [31:0] m;
        logic [32:0] v;
        m = (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
        v = {1'b0, d & m};
        if (P == 1) v[len] = ~^(d & m);
        return {6'(len + P), v};
    endfunction

    // ---------------- scoreboard / line decoder ----------------
    logic [38:0] exp_q[$];
    logic [32:0] mon_bits;
    int          mon_n, stop_len;
    logic        in_stop, p0, p1;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mon_bits = '0; mon_n = 0; in_stop = 1'b0; stop_len = 0; p0 = 1'b1; p1 = 1'b1;
        end else begin
            if (!sl0 && !sl1) begin
                if (!in_stop) begin
                    in_stop = 1'b1;
                    stop_len = 0;
                    if (exp_q.size() == 0) check("sb_unexpected_word", {mon_n[5:0], mon_bits}, 0);
                    else check("sb_word", {mon_n[5:0], mon_bits}, exp_q.pop_front());
                    mon_bits = '0;
                    mon_n = 0;
                end
                stop_len++;
            end else begin
                if (in_stop) check("stop_len", stop_len, SL);
                in_stop = 1'b0;
                if (!sl0 && p0) begin
                    if (mon_n < 33) mon_bits[mon_n] = 1'b0;
                    mon_n++;
                end
                if (!sl1 && p1) begin
                    if (mon_n < 33) mon_bits[mon_n] = 1'b1;
                    mon_n++;
                end
            end
            p0 = sl0;
            p1 = sl1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int id, input logic [31:0] d, input logic [5:0] len);
        bus.req_data[id*32 +: 32] = d;
        bus.req_len[id*6 +: 6] = len;
        bus.req[id] = 1'b1;
    endtask

    task automatic wait_ack(input int max, output int a_cyc);
        a_cyc = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                a_cyc = cyc;
                return;
            end
        end
        check("ack_timeout", 0, 1);
    endtask

    task automatic wait_done(input int max, output int d_cyc);
        d_cyc = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                d_cyc = cyc;
                return;
            end
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_word(input int id, input logic [31:0] d, input int len);
        int a, dn;
        set_req(id, d, 6'(len));
        wait_ack(50, a);
        check("ack_onehot", bus.ack, 4'b1 << id);
        check("ack_err", bus.err, 0);
        check("cur_id", cur_id, id);
        check("busy_at_ack", busy, 1);
        exp_q.push_back(word_model(d, len));
        bus.req[id] = 1'b0;
        wait_done(400, dn);
        check("ack_to_done", dn - a + 1, lat(len));
        @(negedge clk);
        check("busy_after_done", busy, 0);
    endtask

    task automatic reject(input int id, input logic [5:0] len);
        int a;
        set_req(id, 32'hDEAD_BEEF, len);
        wait_ack(50, a);
        check("rej_ack", bus.ack, 4'b1 << id);
        check("rej_err", bus.err, 1);
        check("rej_busy", busy, 0);
        bus.req[id] = 1'b0;
        repeat (3) @(negedge clk);
        check("rej_lines", {sl0, sl1, busy, bus.ack}, {3'b110, 4'b0});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a, prev, dn;
        bus.req = '0;
        bus.req_data = '0;
        bus.req_len = '0;
        repeat (3) @(negedge clk);
        check("rst_lines", {sl0, sl1}, 2'b11);
        check("rst_ack_err", {bus.ack, bus.err}, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_cur_id", cur_id, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single word from requester 2
        send_word(2, 32'h5, 3);

        // illegal lengths
        reject(1, 6'd0);
        reject(1, 6'd33);

        // all four requesting from reset: 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, 32'hA + i, 6'd4);
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            wait_ack(200, a);
            check("rr_order", bus.ack, 4'b1 << (k % N_REQ));
            if (prev >= 0) check("rr_spacing", a - prev, lat(4) + 1);
            prev = a;
            exp_q.push_back(word_model(32'hA + (k % N_REQ), 4));
            if (k == 4) bus.req = '0;
        end
        wait_done(200, dn);
        check("rr_last_latency", dn - prev + 1, lat(4));

        // maximum length
        @(negedge clk);
        send_word(0, 32'hFFFF_FFFF, 32);

        // reset during bit 5 of a word
        set_req(3, 32'h0000_1234, 6'd20);
        wait_ack(50, a);
        bus.req[3] = 1'b0;
        while (cyc < a + 5 * (BL + BH) + 1) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_lines_async", {sl0, sl1}, 2'b11);
        check("abort_busy", busy, 0);
        set_req(3, 32'h3, 6'd2);
        set_req(0, 32'h9, 6'd4);
        repeat (2) @(negedge clk);
        check("abort_no_done", done, 0);
        rst_n = 1'b1;
        wait_ack(20, a);
        check("post_rst_first", bus.ack, 4'b0001);
        exp_q.push_back(word_model(32'h9, 4));
        bus.req[0] = 1'b0;
        wait_ack(200, a);
        check("post_rst_second", bus.ack, 4'b1000);
        exp_q.push_back(word_model(32'h3, 2));
        bus.req[3] = 1'b0;
        wait_done(200, dn);
        check("post_rst_latency", dn - a + 1, lat(2));

        repeat (4) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
